// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: lockout FSM state type and
// default lockout constants used by the timer and the display logic.
package lock_pkg;

    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        LOCKOUT = 1'b1
    } lockout_state_t;

    localparam int LOCK_MAX_FAILS     = 3;
    localparam int LOCK_LOCKOUT_TICKS = 30;
    localparam int LOCK_CNT_W         = 6;
    localparam int LOCK_FAIL_W        = 2;

endpackage

// File: rtl/lockout_timer_if.sv
// Bundle of the lockout timer's attempt inputs, slow tick source and status
// outputs. The code-compare side drives it as master, the timer is the slave.
interface lockout_timer_if #(
    parameter int CNT_W  = lock_pkg::LOCK_CNT_W,
    parameter int FAIL_W = lock_pkg::LOCK_FAIL_W
) ();

    logic              divided_clk;
    logic              attempt_fail;
    logic              attempt_ok;
    logic              locked_out;
    logic [CNT_W-1:0]  ticks_remaining;
    logic [FAIL_W-1:0] fail_count;
    logic              lockout_done;

    modport master (
        output divided_clk,
        output attempt_fail,
        output attempt_ok,
        input  locked_out,
        input  ticks_remaining,
        input  fail_count,
        input  lockout_done
    );

    modport slave (
        input  divided_clk,
        input  attempt_fail,
        input  attempt_ok,
        output locked_out,
        output ticks_remaining,
        output fail_count,
        output lockout_done
    );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for a slow
// asynchronous level. The edge output is combinational from the last two
// flops and lasts exactly one clk_in cycle per rising edge of d.
module edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronise d into clk_in and keep the previous synchronised value
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // s1/s2: metastability settling
            s1 <= d;
            s2 <= s1;
            // s3: previous value for edge detection
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/lockout_timer.sv
// Lockout timer: counts consecutive failed code attempts and, once the
// limit is reached, holds the lock out for a fixed number of rising edges
// of the slow divided clock. The divided clock is sampled as data only.
module lockout_timer
    import lock_pkg::*;
#(
    parameter int MAX_FAILS     = LOCK_MAX_FAILS,
    parameter int LOCKOUT_TICKS = LOCK_LOCKOUT_TICKS,
    parameter int CNT_W         = LOCK_CNT_W,
    parameter int FAIL_W        = LOCK_FAIL_W
) (
    input  logic            clk_in,
    input  logic            rst,
    lockout_timer_if.slave  bus
);

    localparam logic [0:0] ST_ARMED   = 1'(ARMED);
    localparam logic [0:0] ST_LOCKOUT = 1'(LOCKOUT);

    localparam logic [CNT_W-1:0]  LOAD_TICKS = CNT_W'(LOCKOUT_TICKS);
    localparam logic [CNT_W-1:0]  TICK_ONE   = CNT_W'(1);
    localparam logic [FAIL_W-1:0] FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
    localparam logic [FAIL_W-1:0] FAIL_FULL  = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] FAIL_ONE   = FAIL_W'(1);

    logic [0:0]        state;
    logic [CNT_W-1:0]  ticks_q;
    logic [FAIL_W-1:0] fails_q;
    logic              locked_q;
    logic              done_q;
    logic              tick;

    edge_sync u_tick_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (bus.divided_clk),
        .rise   (tick)
    );

    // Lockout FSM with its failure counter, tick countdown and status flags
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= ST_ARMED;
            ticks_q  <= '0;
            fails_q  <= '0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_ARMED: begin
                    // Fail takes priority over ok; ticks are irrelevant here.
                    if (bus.attempt_fail) begin
                        if (fails_q == FAIL_LAST) begin
                            state    <= ST_LOCKOUT;
                            fails_q  <= FAIL_FULL;
                            ticks_q  <= LOAD_TICKS;
                            locked_q <= 1'b1;
                        end else begin
                            fails_q <= fails_q + FAIL_ONE;
                        end
                    end else if (bus.attempt_ok) begin
                        fails_q <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    // Attempts are ignored; only ticks move the countdown.
                    if (tick) begin
                        if (ticks_q > TICK_ONE) begin
                            ticks_q <= ticks_q - TICK_ONE;
                        end else begin
                            state    <= ST_ARMED;
                            ticks_q  <= '0;
                            fails_q  <= '0;
                            locked_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_ARMED;
                end
            endcase
        end
    end

    assign bus.locked_out      = locked_q;
    assign bus.ticks_remaining = ticks_q;
    assign bus.fail_count      = fails_q;
    assign bus.lockout_done    = done_q;

endmodule

// File: tb/tb_lockout_timer.sv
// Directed bench for lockout_timer: one instance at default parameters and
// one with a 4-tick lockout for the countdown sequence.
module tb_lockout_timer;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    lockout_timer_if #(.CNT_W(6), .FAIL_W(2)) bus_a ();
    lockout_timer_if #(.CNT_W(6), .FAIL_W(2)) bus_b ();

    lockout_timer #(
        .MAX_FAILS     (3),
        .LOCKOUT_TICKS (30),
        .CNT_W         (6),
        .FAIL_W        (2)
    ) dut_a (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus_a.slave)
    );

    lockout_timer #(
        .MAX_FAILS     (3),
        .LOCKOUT_TICKS (4),
        .CNT_W         (6),
        .FAIL_W        (2)
    ) dut_b (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus_b.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clk_in edge and settle just after it
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check_a(input string tag, input int lo, input int tr, input int fc, input int dn);
        check({tag, ".locked_a"}, int'(bus_a.locked_out), lo);
        check({tag, ".ticks_a"},  int'(bus_a.ticks_remaining), tr);
        check({tag, ".fails_a"},  int'(bus_a.fail_count), fc);
        check({tag, ".done_a"},   int'(bus_a.lockout_done), dn);
    endtask

    task automatic check_b(input string tag, input int lo, input int tr, input int fc, input int dn);
        check({tag, ".locked_b"}, int'(bus_b.locked_out), lo);
        check({tag, ".ticks_b"},  int'(bus_b.ticks_remaining), tr);
        check({tag, ".fails_b"},  int'(bus_b.fail_count), fc);
        check({tag, ".done_b"},   int'(bus_b.lockout_done), dn);
    endtask

    task automatic fail_a();
        bus_a.attempt_fail = 1'b1;
        step();
        bus_a.attempt_fail = 1'b0;
    endtask

    task automatic ok_a();
        bus_a.attempt_ok = 1'b1;
        step();
        bus_a.attempt_ok = 1'b0;
    endtask

    task automatic fail_b();
        bus_b.attempt_fail = 1'b1;
        step();
        bus_b.attempt_fail = 1'b0;
    endtask

    // One divided_clk period of 20 cycles on instance A
    task automatic dclk_period_a();
        bus_a.divided_clk = 1'b1;
        step(10);
        bus_a.divided_clk = 1'b0;
        step(10);
    endtask

    initial begin
        bus_a.divided_clk  = 1'b0;
        bus_a.attempt_fail = 1'b0;
        bus_a.attempt_ok   = 1'b0;
        bus_b.divided_clk  = 1'b0;
        bus_b.attempt_fail = 1'b0;
        bus_b.attempt_ok   = 1'b0;

        // Reset and ARMED handling
        rst = 1'b1;
        step(3);
        check_a("reset", 0, 0, 0, 0);
        check_b("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step(2);
        fail_a();
        check_a("fail1", 0, 0, 1, 0);
        fail_a();
        check_a("fail2", 0, 0, 2, 0);
        ok_a();
        check_a("ok_clear", 0, 0, 0, 0);

        // Lockout entry on the edge sampling the third failure
        fail_a();
        fail_a();
        check_a("pre_lock", 0, 0, 2, 0);
        fail_a();
        check_a("lock_entry", 1, 30, 3, 0);

        // Attempts ignored in LOCKOUT
        fail_a();
        check_a("lock_ign_fail", 1, 30, 3, 0);
        ok_a();
        check_a("lock_ign_ok", 1, 30, 3, 0);
        bus_a.attempt_fail = 1'b1;
        bus_a.attempt_ok   = 1'b1;
        step();
        bus_a.attempt_fail = 1'b0;
        bus_a.attempt_ok   = 1'b0;
        check_a("lock_ign_both", 1, 30, 3, 0);

        // Count down 13 ticks to 17, then reset mid-lockout
        for (int i = 0; i < 13; i++) dclk_period_a();
        check_a("at17", 1, 17, 3, 0);
        bus_a.divided_clk = 1'b1;
        rst = 1'b1;
        step();
        check_a("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        step(6);
        check_a("spurious_tick", 0, 0, 0, 0);
        bus_a.divided_clk = 1'b0;
        step(4);

        // Simultaneous fail and ok with two failures recorded
        fail_a();
        fail_a();
        check_a("sim_pre", 0, 0, 2, 0);
        bus_a.attempt_fail = 1'b1;
        bus_a.attempt_ok   = 1'b1;
        step();
        bus_a.attempt_fail = 1'b0;
        bus_a.attempt_ok   = 1'b0;
        check_a("sim_both", 1, 30, 3, 0);

        // Tick coinciding with the lockout entry cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(4);
        fail_a();
        fail_a();
        bus_a.divided_clk = 1'b1;
        step(2);
        bus_a.attempt_fail = 1'b1;
        step();
        bus_a.attempt_fail = 1'b0;
        check_a("entry_tick", 1, 30, 3, 0);
        step(5);
        check_a("entry_tick_hold", 1, 30, 3, 0);
        bus_a.divided_clk = 1'b0;

        // Countdown on the 4-tick instance, 20-cycle divided_clk
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(4);
        fail_b();
        fail_b();
        fail_b();
        check_b("b_entry", 1, 4, 3, 0);
        for (int t = 3; t >= 0; t--) begin
            bus_b.divided_clk = 1'b1;
            step(2);
            check_b($sformatf("b_before_%0d", t), 1, t + 1, 3, 0);
            step();
            if (t > 0) begin
                check_b($sformatf("b_step_%0d", t), 1, t, 3, 0);
            end else begin
                check_b("b_exit", 0, 0, 0, 1);
            end
            step();
            if (t == 0) begin
                check_b("b_done_clear", 0, 0, 0, 0);
            end
            step(6);
            bus_b.divided_clk = 1'b0;
            step(10);
        end
        check_b("b_armed_after", 0, 0, 0, 0);
        fail_b();
        check_b("b_rearm_fail", 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lockout_timer.md
# lockout_timer

Lockout timer for the digital lock: counts consecutive failed code attempts and, after `MAX_FAILS` failures, holds the lock in a timed lockout measured in rising edges of the slow `divided_clk` from `clk_divider`. It sits directly downstream of `clk_divider` and beside the code-compare logic, which supplies the attempt pulses. `divided_clk` is treated as data: it is synchronised and edge-detected, never used as a clock.

## Interface
- `MAX_FAILS`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_TICKS`, 30: lockout length in `divided_clk` rising edges (≥1). At the default `clk_divider` setting this is ~15 s.
- `CNT_W`, 6: width of `ticks_remaining`. Must satisfy `LOCKOUT_TICKS < 2**CNT_W`.
- `FAIL_W`, 2: width of `fail_count`. Must satisfy `MAX_FAILS < 2**FAIL_W`.

Ports:
- `clk_in`, in, 1: system clock, 40 MHz. This design has one clock.
- `rst`, in, 1: synchronous, active-high reset.
- `divided_clk`, in, 1: slow square wave from `clk_divider`, asynchronous to the logic here.
- `attempt_fail`, in, 1: one-cycle pulse meaning a wrong code was entered.
- `attempt_ok`, in, 1: one-cycle pulse meaning the correct code was entered.
- `locked_out`, out, 1: high while in LOCKOUT. Resets to 0.
- `ticks_remaining`, out, `CNT_W`: ticks left in the lockout; 0 outside lockout. Resets to 0.
- `fail_count`, out, `FAIL_W`: current consecutive-failure count. Resets to 0.
- `lockout_done`, out, 1: one-cycle pulse when a lockout expires. Resets to 0.

## Operation
- Tick generation:
  - `divided_clk` passes through two sync flops, `s1` and `s2`, then a previous-value flop `s3`.
  - `tick = s2 & ~s3`. All three flops reset to 0.
- States are ARMED (reset state) and LOCKOUT.
- ARMED, priority order:
  - `attempt_fail` with `fail_count == MAX_FAILS-1` → enter LOCKOUT. `fail_count <= MAX_FAILS`, `ticks_remaining <= LOCKOUT_TICKS`, `locked_out <= 1`.
  - Otherwise `attempt_fail` → `fail_count` increments.
  - Otherwise `attempt_ok` → `fail_count <= 0`.
  - Simultaneous `attempt_fail` and `attempt_ok`: fail wins (conservative).
  - Ticks are ignored.
- LOCKOUT:
  - `attempt_fail` and `attempt_ok` are ignored; the count does not change.
  - On `tick` with `ticks_remaining > 1` → decrement.
  - On `tick` with `ticks_remaining == 1` → return to ARMED. Same edge: `ticks_remaining <= 0`, `fail_count <= 0`, `locked_out <= 0`, `lockout_done <= 1` for exactly one cycle.
  - A tick in the same cycle as LOCKOUT entry is ignored; the load value wins.
- `rst` overrides everything. From any state it forces ARMED, clears all outputs and the sync flops, and takes effect on the next `clk_in` edge. A mid-lockout reset therefore drops the lockout immediately.
- Arithmetic:
  - The counters never wrap.
  - `fail_count` saturates by construction at `MAX_FAILS`.
  - `ticks_remaining` is never decremented below 1 by a tick; the transition to 0 is the exit.

## Timing
- `divided_clk` rising before `clk_in` edge k:
  - `tick` is high during the cycle after edge k+1.
  - The decrement or exit is visible after edge k+2.
  - Latency is therefore 3 edges, with ±1 edge of metastability uncertainty.
- If `divided_clk` is high when `rst` deasserts, one spurious tick occurs 2 cycles later. In ARMED it is harmless and needs no filtering.
- `attempt_fail` sampled at edge n → `fail_count` / `locked_out` update is visible after edge n. This is a single-cycle response.
- `lockout_done` is high for exactly one `clk_in` cycle, coincident with `locked_out` falling.
- Attempt pulses are assumed single-cycle. A held level counts once per cycle.

## Structure
- Shared package `lock_pkg` holds:
  - the state enum `lockout_state_t` {ARMED, LOCKOUT};
  - default constants `LOCK_MAX_FAILS` and `LOCK_LOCKOUT_TICKS`, reused by the top level and the display logic.
- One sub-module, `edge_sync`: the 2-flop synchroniser plus rising-edge detector, with ports `clk_in`, `rst`, `d`, `rise`. It is reusable for the keypad inputs.
- The FSM, the counters and the output registers live in `lockout_timer`.

## Test plan
- Reset and ARMED handling: after `rst`, all outputs are 0. Two `attempt_fail` pulses → `fail_count` = 2, `locked_out` = 0. Then `attempt_ok` → `fail_count` = 0.
- Lockout entry: three `attempt_fail` pulses → `locked_out` = 1, `ticks_remaining` = 30, `fail_count` = 3 on the edge sampling the third pulse.
- Tick countdown: with `LOCKOUT_TICKS` = 4 and a fast `divided_clk` (period 20 cycles), `ticks_remaining` goes 4, 3, 2, 1, 0. Each step lands 3 edges after a `divided_clk` rise. On the final step: `lockout_done` pulses for 1 cycle, `locked_out` = 0, `fail_count` = 0.
- Ignored inputs during lockout: pulse `attempt_fail` and `attempt_ok` during LOCKOUT, and raise both in the same cycle while ARMED with `fail_count` = 2. LOCKOUT: no change. Simultaneous case: lockout is entered.
- Reset mid-lockout: assert `rst` at `ticks_remaining` = 17 → next edge has all outputs 0 and ARMED. A held-high `divided_clk` produces one tick and no state change.
- Tick on the entry cycle: align a tick with the third `attempt_fail` → `ticks_remaining` = `LOCKOUT_TICKS`, not `LOCKOUT_TICKS`-1.
